// File: rtl/sdram_req_arbiter_pkg.sv
// Shared types and defaults for the SDRAM request arbiter: FSM state encoding,
// default address widths and watchdog limit, and the round-robin wrap helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_ROW_W          = 12;
    localparam int DEF_COL_W          = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Index reached by stepping 'step' places past 'base' on a ring of size n.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Requester and controller-command signals of the SDRAM request arbiter.
// master = arbiter side, slave = requesters plus sdram_controller side.
interface sdram_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ROW_W   = 12,
    parameter int COL_W   = 8
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    // Requester handshake: a request transfers on the rising edge where
    // io_req_valid[i] and io_req_ready[i] are both high; valid must be held
    // until then and may drop freely afterwards.
    logic [NUM_REQ-1:0]       io_req_valid;
    logic [NUM_REQ-1:0]       io_req_write;
    logic [NUM_REQ*ROW_W-1:0] io_req_row;
    logic [NUM_REQ*COL_W-1:0] io_req_col;
    logic [NUM_REQ-1:0]       io_req_ready;
    logic [NUM_REQ-1:0]       io_resp_done;
    logic [NUM_REQ-1:0]       io_resp_error;

    logic                     io_read_start_0;
    logic [ROW_W-1:0]         io_read_row_addresses_0;
    logic [COL_W-1:0]         io_read_col_addresses_0;
    logic                     io_read_data_valid_0;
    logic                     io_write_start_0;
    logic [ROW_W-1:0]         io_write_row_addresses_0;
    logic [COL_W-1:0]         io_write_col_addresses_0;
    logic                     io_write_data_valid_0;

    logic                     io_busy;
    logic [OWNER_W-1:0]       io_owner;

    modport master (
        input  io_req_valid, io_req_write, io_req_row, io_req_col,
        input  io_read_data_valid_0, io_write_data_valid_0,
        output io_req_ready, io_resp_done, io_resp_error,
        output io_read_start_0, io_read_row_addresses_0, io_read_col_addresses_0,
        output io_write_start_0, io_write_row_addresses_0, io_write_col_addresses_0,
        output io_busy, io_owner
    );

    modport slave (
        output io_req_valid, io_req_write, io_req_row, io_req_col,
        output io_read_data_valid_0, io_write_data_valid_0,
        input  io_req_ready, io_resp_done, io_resp_error,
        input  io_read_start_0, io_read_row_addresses_0, io_read_col_addresses_0,
        input  io_write_start_0, io_write_row_addresses_0, io_write_col_addresses_0,
        input  io_busy, io_owner
    );

endinterface

// File: rtl/sdram_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first valid requester found searching
// upward from last_grant+1 (wrapping) wins; one-hot grant plus its index.
module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest candidate to the nearest so the nearest valid one
    // is the last assignment and therefore the winner.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        cand_idx    = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand_idx = IDX_W'(rr_wrap(32'(last_grant_i), k, NUM_REQ));
            if (req_valid_i[cand_idx]) begin
                grant_o           = '0;
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one sdram_controller command port among NUM_REQ
// requesters. Optional WAIT watchdog is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ROW_W   = DEF_ROW_W,
    parameter int COL_W   = DEF_COL_W
`ifdef SDRAM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                clock,
    input  logic                reset,
    sdram_req_arbiter_if.master io,
    output state_t              dbg_state_o
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    state_t             state_q;
    logic               busy_q;
    logic               rd_start_q;
    logic               wr_start_q;
    logic               write_q;
    logic [NUM_REQ-1:0] done_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [OWNER_W-1:0] owner_q;
    logic [OWNER_W-1:0] last_grant_q;

    logic [NUM_REQ-1:0] grant_d;
    logic [OWNER_W-1:0] grant_idx_d;
    logic [ROW_W-1:0]   row_d;
    logic [COL_W-1:0]   col_d;
    logic               write_d;
    logic               cpl_d;
    logic [NUM_REQ-1:0] owner_oh_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_valid_i  (io.io_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_d),
        .grant_idx_o  (grant_idx_d)
    );

    always_comb begin
        row_d   = '0;
        col_d   = '0;
        write_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_d[i]) begin
                row_d   = io.io_req_row[i*ROW_W +: ROW_W];
                col_d   = io.io_req_col[i*COL_W +: COL_W];
                write_d = io.io_req_write[i];
            end
        end
    end

    // Only the strobe matching the latched operation can finish the wait.
    assign cpl_d      = write_q ? io.io_write_data_valid_0 : io.io_read_data_valid_0;
    assign owner_oh_d = NUM_REQ'(1) << owner_q;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]   tmo_cnt_q;
    logic [NUM_REQ-1:0] err_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            rd_start_q   <= 1'b0;
            wr_start_q   <= 1'b0;
            write_q      <= 1'b0;
            done_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            owner_q      <= '0;
            last_grant_q <= OWNER_W'(NUM_REQ - 1);
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= '0;
`endif
        end else begin
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            done_q     <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            err_q      <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (|io.io_req_valid) begin
                        row_q      <= row_d;
                        col_q      <= col_d;
                        write_q    <= write_d;
                        owner_q    <= grant_idx_d;
                        wr_start_q <= write_d;
                        rd_start_q <= ~write_d;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cpl_d) begin
                        done_q  <= owner_oh_d;
                        state_q <= DONE;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        err_q   <= owner_oh_d;
                        state_q <= DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    last_grant_q <= owner_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Acceptance is decided in IDLE from the live request vector.
    assign io.io_req_ready = (state_q == IDLE && !reset) ? grant_d : '0;
    assign io.io_resp_done = done_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    assign io.io_resp_error = err_q;
`else
    assign io.io_resp_error = '0;
`endif

    assign io.io_read_start_0          = rd_start_q;
    assign io.io_read_row_addresses_0  = row_q;
    assign io.io_read_col_addresses_0  = col_q;
    assign io.io_write_start_0         = wr_start_q;
    assign io.io_write_row_addresses_0 = row_q;
    assign io.io_write_col_addresses_0 = col_q;
    assign io.io_busy                  = busy_q;
    assign io.io_owner                 = owner_q;
    assign dbg_state_o                 = state_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench for sdram_req_arbiter: command and completion scoreboards
// plus directed timing checks; timeout scenario when SDRAM_ARB_TIMEOUT_EN is set.
module tb_sdram_req_arbiter;
  import sdram_arb_pkg::*;

  localparam int N     = 2;
  localparam int RW    = 12;
  localparam int CW    = 8;
  localparam int OW    = 1;
  localparam int CMD_W = 1 + OW + RW + CW;

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     cyc = 0;
  int     num_checks = 0;
  int     num_fail = 0;
  int     err_cycle = -1;

  logic [CMD_W-1:0] exp_q[$];
  logic [N-1:0]     exp_done_q[$];
  logic [N-1:0]     exp_err_q[$];

  sdram_req_arbiter_if #(.NUM_REQ(N), .ROW_W(RW), .COL_W(CW)) io ();

`ifdef SDRAM_ARB_TIMEOUT_EN
  sdram_req_arbiter #(.NUM_REQ(N), .ROW_W(RW), .COL_W(CW), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .io(io), .dbg_state_o(dbg_state));
`else
  sdram_req_arbiter #(.NUM_REQ(N), .ROW_W(RW), .COL_W(CW)) dut (
    .clock(clock), .reset(reset), .io(io), .dbg_state_o(dbg_state));
`endif

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CMD_W-1:0] pack_cmd(input logic wr, input logic [OW-1:0] own,
                                                input logic [RW-1:0] r, input logic [CW-1:0] c);
    return {wr, own, r, c};
  endfunction

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_busy"}, io.io_busy, 1'b0);
    check({pfx, "_ready"}, io.io_req_ready, '0);
    check({pfx, "_starts"}, {io.io_read_start_0, io.io_write_start_0}, 2'b00);
    check({pfx, "_done"}, io.io_resp_done, '0);
    check({pfx, "_error"}, io.io_resp_error, '0);
    check({pfx, "_owner"}, io.io_owner, '0);
    check({pfx, "_rd_addr"}, {io.io_read_row_addresses_0, io.io_read_col_addresses_0}, '0);
    check({pfx, "_wr_addr"}, {io.io_write_row_addresses_0, io.io_write_col_addresses_0}, '0);
    check({pfx, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic req_drive(input int i, input logic wr, input logic [RW-1:0] r, input logic [CW-1:0] c);
    int n = 0;
    @(posedge clock); #1;
    io.io_req_write[i]          = wr;
    io.io_req_row[i*RW +: RW]   = r;
    io.io_req_col[i*CW +: CW]   = c;
    io.io_req_valid[i]          = 1'b1;
    @(negedge clock);
    while (!io.io_req_ready[i] && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!io.io_req_ready[i]) check($sformatf("req%0d_accept", i), io.io_req_ready[i], 1'b1);
    @(posedge clock); #1;
    io.io_req_valid[i] = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    @(negedge clock);
    while (!(io.io_read_start_0 || io.io_write_start_0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!(io.io_read_start_0 || io.io_write_start_0))
      check("ctl_start_seen", io.io_read_start_0 | io.io_write_start_0, 1'b1);
  endtask

  // Controller model: answer the next command with the matching strobe after lat cycles.
  task automatic controller(input int lat);
    logic wr;
    wait_start();
    wr = io.io_write_start_0;
    repeat (lat) @(posedge clock);
    #1;
    if (wr) io.io_write_data_valid_0 = 1'b1;
    else    io.io_read_data_valid_0  = 1'b1;
    @(posedge clock); #1;
    io.io_write_data_valid_0 = 1'b0;
    io.io_read_data_valid_0  = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (io.io_read_start_0 || io.io_write_start_0) begin
        check("one_strobe", io.io_read_start_0 & io.io_write_start_0, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {io.io_read_start_0, io.io_write_start_0}, 2'b00);
        end else begin
          logic [CMD_W-1:0] e;
          e = exp_q.pop_front();
          check("cmd_rd_bus", {io.io_write_start_0, io.io_owner,
                               io.io_read_row_addresses_0, io.io_read_col_addresses_0}, e);
          check("cmd_wr_bus", {io.io_write_start_0, io.io_owner,
                               io.io_write_row_addresses_0, io.io_write_col_addresses_0}, e);
        end
      end
      if (io.io_resp_done != '0) begin
        if (exp_done_q.size() == 0) check("unexpected_done", io.io_resp_done, '0);
        else                        check("done", io.io_resp_done, exp_done_q.pop_front());
      end
      if (io.io_resp_error != '0) begin
        err_cycle = cyc;
        if (exp_err_q.size() == 0) check("unexpected_error", io.io_resp_error, '0);
        else                       check("error", io.io_resp_error, exp_err_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    io.io_req_valid          = '0;
    io.io_req_write          = '0;
    io.io_req_row            = '0;
    io.io_req_col            = '0;
    io.io_read_data_valid_0  = 1'b0;
    io.io_write_data_valid_0 = 1'b0;

    apply_reset();
    @(negedge clock);
    check_idle("rst");

    // Contention from reset: grants alternate 0,1,0,1.
    exp_q.push_back(pack_cmd(1'b0, 1'b0, 12'h100, 8'h10)); exp_done_q.push_back(2'b01);
    exp_q.push_back(pack_cmd(1'b1, 1'b1, 12'h200, 8'h20)); exp_done_q.push_back(2'b10);
    exp_q.push_back(pack_cmd(1'b0, 1'b0, 12'h101, 8'h11)); exp_done_q.push_back(2'b01);
    exp_q.push_back(pack_cmd(1'b1, 1'b1, 12'h201, 8'h21)); exp_done_q.push_back(2'b10);
    fork
      begin req_drive(0, 1'b0, 12'h100, 8'h10); req_drive(0, 1'b0, 12'h101, 8'h11); end
      begin req_drive(1, 1'b1, 12'h200, 8'h20); req_drive(1, 1'b1, 12'h201, 8'h21); end
      begin repeat (4) controller(2); end
    join
    repeat (4) @(posedge clock);

    // Write routing with a stray read completion during WAIT.
    exp_q.push_back(pack_cmd(1'b1, 1'b1, 12'hFFF, 8'hFF)); exp_done_q.push_back(2'b10);
    fork
      req_drive(1, 1'b1, 12'hFFF, 8'hFF);
      begin
        wait_start();
        @(posedge clock); #1;
        io.io_read_data_valid_0 = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        io.io_read_data_valid_0 = 1'b0;
        @(negedge clock);
        check("wr_busy_after_stray", io.io_busy, 1'b1);
        check("wr_state_after_stray", dbg_state, WAIT);
        @(posedge clock); #1;
        io.io_write_data_valid_0 = 1'b1;
        @(posedge clock); #1;
        io.io_write_data_valid_0 = 1'b0;
      end
    join
    repeat (4) @(posedge clock);

    // Single read with exact cycle timing; T is the cycle ready is high.
    exp_q.push_back(pack_cmd(1'b0, 1'b0, 12'h123, 8'h45)); exp_done_q.push_back(2'b01);
    @(posedge clock); #1;
    io.io_req_write[0]     = 1'b0;
    io.io_req_row[0 +: RW] = 12'h123;
    io.io_req_col[0 +: CW] = 8'h45;
    io.io_req_valid[0]     = 1'b1;
    @(negedge clock);
    check("rd_ready_T", io.io_req_ready, 2'b01);
    @(posedge clock); #1;
    io.io_req_valid[0] = 1'b0;
    @(negedge clock);
    check("rd_start_T1", {io.io_read_start_0, io.io_write_start_0}, 2'b10);
    @(posedge clock);
    @(posedge clock); #1;
    io.io_read_data_valid_0 = 1'b1;
    @(negedge clock);
    check("rd_no_done_T3", io.io_resp_done, 2'b00);
    @(posedge clock); #1;
    io.io_read_data_valid_0 = 1'b0;
    @(negedge clock);
    check("rd_done_T4", io.io_resp_done, 2'b01);
    check("rd_busy_T4", io.io_busy, 1'b1);
    @(negedge clock);
    check("rd_idle_T5", io.io_busy, 1'b0);

    // Reset while waiting: no done, idle outputs, requester 0 wins afterwards.
    exp_q.push_back(pack_cmd(1'b0, 1'b0, 12'h3C3, 8'h5A));
    req_drive(0, 1'b0, 12'h3C3, 8'h5A);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle("abort");
    exp_q.push_back(pack_cmd(1'b0, 1'b0, 12'h011, 8'h22)); exp_done_q.push_back(2'b01);
    exp_q.push_back(pack_cmd(1'b0, 1'b1, 12'h033, 8'h44)); exp_done_q.push_back(2'b10);
    fork
      req_drive(0, 1'b0, 12'h011, 8'h22);
      req_drive(1, 1'b0, 12'h033, 8'h44);
      begin repeat (2) controller($urandom_range(1, 5)); end
    join
    repeat (4) @(posedge clock);

`ifdef SDRAM_ARB_TIMEOUT_EN
    begin
      int s_cyc;
      exp_q.push_back(pack_cmd(1'b0, 1'b0, 12'h0AA, 8'h0B));
      exp_err_q.push_back(2'b01);
      err_cycle = -1;
      req_drive(0, 1'b0, 12'h0AA, 8'h0B);
      s_cyc = cyc;
      repeat (15) @(negedge clock);
      check("to_err_latency", err_cycle - s_cyc, 9);
      check("to_idle_after", io.io_busy, 1'b0);
      exp_q.push_back(pack_cmd(1'b1, 1'b1, 12'h055, 8'h66)); exp_done_q.push_back(2'b10);
      fork
        req_drive(1, 1'b1, 12'h055, 8'h66);
        controller(1);
      join
      repeat (4) @(posedge clock);
    end
`else
    exp_q.push_back(pack_cmd(1'b0, 1'b0, 12'h777, 8'h88));
    req_drive(0, 1'b0, 12'h777, 8'h88);
    for (int k = 0; k < 10; k++) begin
      repeat (100) @(negedge clock);
      check($sformatf("hang_busy_%0d", k), io.io_busy, 1'b1);
      check($sformatf("hang_error_%0d", k), io.io_resp_error, 2'b00);
    end
    apply_reset();
    @(negedge clock);
    check("hang_reset_busy", io.io_busy, 1'b0);
`endif

    repeat (3) @(negedge clock);
    check("sb_cmd_drain", exp_q.size(), 0);
    check("sb_done_drain", exp_done_q.size(), 0);
    check("sb_err_drain", exp_err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
# sdram_req_arbiter

Shares the single `sdram_controller` read/write command port between `NUM_REQ` independent requesters. Requests are granted in round-robin order and issued to the controller one at a time. The block waits for the controller's completion strobe before returning a done pulse to the owner. It sits directly in front of `sdram_controller` inside `tt_um_gmejiamtz` and drives the controller's `io_read_*` and `io_write_*` command inputs.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2..4.
- `ROW_W`, default 12: row address width.
- `COL_W`, default 8: column address width.
- `TIMEOUT_CYCLES`, default 64: WAIT-state watchdog limit; used only with `SDRAM_ARB_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `io_req_valid` in NUM_REQ: per-requester request pending; must be held until the matching `io_req_ready` pulse.
- `io_req_write` in NUM_REQ: 1 = write, 0 = read.
- `io_req_row` in NUM_REQ*ROW_W: packed row address; requester i occupies bits [i*ROW_W +: ROW_W].
- `io_req_col` in NUM_REQ*COL_W: packed column address, packed the same way.
- `io_req_ready` out NUM_REQ: one-hot acceptance pulse, 1 cycle.
- `io_resp_done` out NUM_REQ: one-hot completion pulse, 1 cycle.
- `io_resp_error` out NUM_REQ: one-hot timeout pulse, 1 cycle; tied to 0 without the macro.
- `io_read_start_0` out 1: read command strobe to the controller.
- `io_read_row_addresses_0` out ROW_W: read row address to the controller.
- `io_read_col_addresses_0` out COL_W: read column address to the controller.
- `io_read_data_valid_0` in 1: read completion strobe from the controller.
- `io_write_start_0` out 1: write command strobe to the controller.
- `io_write_row_addresses_0` out ROW_W: write row address to the controller.
- `io_write_col_addresses_0` out COL_W: write column address to the controller.
- `io_write_data_valid_0` in 1: write completion strobe from the controller.
- `io_busy` out 1: high in every state except IDLE.
- `io_owner` out $clog2(NUM_REQ): index of the current or last owner.

## Operation
- FSM states are IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any `io_req_valid` bit is set, pick the winner by round-robin, searching upward from `last_grant+1` and wrapping modulo NUM_REQ.
  - Pulse `io_req_ready[winner]`.
  - Latch the winner's row, column and write bit, and set `owner=winner`.
  - Go to ISSUE.
  - With no requests pending, stay in IDLE.
- **ISSUE**
  - Assert exactly one strobe for one cycle: `io_write_start_0` if the latched write bit is 1, otherwise `io_read_start_0`.
  - Go to WAIT.
- **WAIT**
  - Sample only the completion strobe that matches the latched operation; the other strobe is ignored.
  - When the matching strobe is high, go to DONE.
- **DONE**
  - Pulse `io_resp_done[owner]`, set `last_grant=owner`, and go to IDLE.
- Address outputs hold the latched values from ISSUE through DONE and hold their last values while in IDLE. Both address buses carry the same latched values.
- Completion strobes are ignored outside WAIT.
- A requester that drops `io_req_valid` before `io_req_ready` is never granted. Dropping valid after the grant has no effect on the transaction.
- **Reset:** state = IDLE; all strobes, ready, done, error and busy = 0; addresses = 0; `owner` = 0; `last_grant` = NUM_REQ-1, so requester 0 wins first.
- **Reset mid-transaction:** the transaction is abandoned with no done pulse. The requester reissues it.

## Timing
- Accept at cycle T, start strobe at T+1.
- The earliest completion strobe is sampled at T+2, giving `io_resp_done` at T+3 and the next possible accept at T+4.
- Sustained throughput is therefore at most one transaction per 4 cycles, plus controller latency.
- Simultaneous requests are serialized round-robin. Each persistent requester waits at most NUM_REQ-1 transactions.

## Configuration
- `SDRAM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 with no completion, the FSM goes to DONE.
  - In that case DONE pulses `io_resp_error[owner]` and does not pulse `io_resp_done`.
  - `last_grant` updates normally.
- Undefined: no counter. WAIT waits indefinitely and `io_resp_error` is constant 0.

## Structure
- Package `sdram_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - the default width constants (ROW_W, COL_W);
  - the default timeout constant.
- Sub-module `rr_arbiter`: a combinational round-robin picker. Inputs are the `io_req_valid` vector and `last_grant`. Outputs are a one-hot grant and its index.

## Test plan
- Single read: req0 valid with row=0x123, col=0x45 → ready0 at T, `io_read_start_0` at T+1 with those addresses, controller valid at T+3 → done0 at T+4.
- Contention: req0 and req1 held valid from reset → grant order 0, 1, 0, 1 across four transactions; no starvation.
- Write routing: req1 write with row=0xFFF, col=0xFF → only `io_write_start_0` pulses; a stray `io_read_data_valid_0` in WAIT is ignored; done only after `io_write_data_valid_0`.
- Reset in WAIT: assert `reset` for 1 cycle → next cycle idle outputs are 0, no done pulse, and requester 0 wins the next grant.
- Timeout (macro on, TIMEOUT_CYCLES=8): controller never responds → `io_resp_error[owner]` pulses 8 cycles after WAIT entry, `io_resp_done` stays 0, and the next request is accepted.
- Macro off: no response for 1000 cycles → `io_busy` stays 1 and `io_resp_error` stays 0.
